// File: rtl/apb_master_nslv_pkg.sv
//==============================================================================
// Module : apb_master_pkg
// Brief  : Shared types, status codes and sizing helper for the APB3 master.
// Rev    : 1.0
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

package apb_master_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    localparam logic [1:0] APB_STATE_DISABLED = 2'd0;
    localparam logic [1:0] APB_STATE_IDLE     = 2'd1;
    localparam logic [1:0] APB_STATE_READ     = 2'd2;
    localparam logic [1:0] APB_STATE_WRITE    = 2'd3;

    // Index width for n items, never below one bit.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

`default_nettype wire

// File: rtl/apb_master_nslv_rsp_mux.sv
//==============================================================================
// Module : apb_rsp_mux
// Brief  : Selects the addressed slave's PRDATA/PREADY/PSLVERR; flags decode errors.
// Rev    : 1.0
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module apb_rsp_mux #(
    parameter int N_SLV = 4,
    parameter int DW    = 32,
    parameter int SELW  = 2
) (
    input  logic [SELW-1:0]     sel,
    input  logic [N_SLV*DW-1:0] prdata,
    input  logic [N_SLV-1:0]    pready,
    input  logic [N_SLV-1:0]    pslverr,
    output logic [DW-1:0]       sel_prdata,
    output logic                sel_pready,
    output logic                sel_pslverr,
    output logic                dec_err
);

    // An out-of-range index matches no slave, so all selected fields read as zero.
    always_comb begin
        sel_prdata  = '0;
        sel_pready  = 1'b0;
        sel_pslverr = 1'b0;
        for (int i = 0; i < N_SLV; i++) begin
            if (sel == SELW'(i)) begin
                sel_prdata  = prdata[i*DW +: DW];
                sel_pready  = pready[i];
                sel_pslverr = pslverr[i];
            end
        end
    end

    assign dec_err = (int'(sel) >= N_SLV);

endmodule

`default_nettype wire

// File: rtl/apb_master_nslv.sv
//==============================================================================
// Module : apb_master_nslv
// Brief  : APB3 master for N_SLV slaves with timeout, decode error and back-to-back support.
// Rev    : 1.0
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module apb_master_nslv
    import apb_master_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int N_SLV   = 4,
    parameter int SELW    = clog2_min1(N_SLV),
    parameter int TIMEOUT = 256
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_write,
    input  logic [SELW-1:0]     cmd_sel,
    input  logic [AW-1:0]       cmd_addr,
    input  logic [DW-1:0]       cmd_wdata,
    input  logic                rsp_full,
    output logic                rsp_wen,
    output logic [DW-1:0]       rsp_rdata,
    output logic                rsp_err,
    output logic                rsp_tmo,
    output logic [1:0]          apb_state,
    output logic [N_SLV-1:0]    psel,
    output logic                penable,
    output logic                pwrite,
    output logic [AW-1:0]       paddr,
    output logic [DW-1:0]       pwdata,
    input  logic [N_SLV*DW-1:0] prdata,
    input  logic [N_SLV-1:0]    pready,
    input  logic [N_SLV-1:0]    pslverr
);

    localparam int              CW         = clog2_min1(TIMEOUT + 1);
    localparam logic [CW-1:0]   c_tmo_last = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    state_t            r_state;
    logic [SELW-1:0]   r_sel;
    logic [CW-1:0]     r_cnt;

    logic [DW-1:0]     w_sel_prdata;
    logic              w_sel_pready;
    logic              w_sel_pslverr;
    logic              w_dec_err;
    logic              w_tmo_hit;
    logic              w_tmo;
    logic              w_done;
    logic              w_accept;
    logic [N_SLV-1:0]  w_psel_dec;

    apb_rsp_mux #(
        .N_SLV (N_SLV),
        .DW    (DW),
        .SELW  (SELW)
    ) u_rsp_mux (
        .sel         (r_sel),
        .prdata      (prdata),
        .pready      (pready),
        .pslverr     (pslverr),
        .sel_prdata  (w_sel_prdata),
        .sel_pready  (w_sel_pready),
        .sel_pslverr (w_sel_pslverr),
        .dec_err     (w_dec_err)
    );

    assign w_tmo_hit = (TIMEOUT != 0) && (r_cnt == c_tmo_last);
    assign w_done    = (r_state == ST_ACCESS) && (w_sel_pready || w_dec_err || w_tmo_hit);
    // A ready slave in the final counted cycle wins over the timeout.
    assign w_tmo     = w_tmo_hit && !w_sel_pready && !w_dec_err;
    assign cmd_ready = en && !rsp_full && ((r_state == ST_IDLE) || w_done);
    assign w_accept  = cmd_valid && cmd_ready;

    always_comb begin
        w_psel_dec = '0;
        for (int i = 0; i < N_SLV; i++) begin
            if (cmd_sel == SELW'(i)) w_psel_dec[i] = 1'b1;
        end
    end

    always_comb begin
        if (!en)                                              apb_state = APB_STATE_DISABLED;
        else if (r_state == ST_SETUP || r_state == ST_ACCESS) apb_state = pwrite ? APB_STATE_WRITE : APB_STATE_READ;
        else                                                  apb_state = APB_STATE_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_sel     <= '0;
            r_cnt     <= '0;
            psel      <= '0;
            penable   <= 1'b0;
            pwrite    <= 1'b0;
            paddr     <= '0;
            pwdata    <= '0;
            rsp_wen   <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            rsp_tmo   <= 1'b0;
        end else begin
            rsp_wen <= 1'b0;
            case (r_state)
                ST_IDLE: ;
                ST_SETUP: begin
                    r_state <= ST_ACCESS;
                    penable <= 1'b1;
                    r_cnt   <= '0;
                end
                ST_ACCESS: begin
                    if (w_done) begin
                        rsp_wen   <= 1'b1;
                        rsp_rdata <= (!pwrite && w_sel_pready) ? w_sel_prdata : '0;
                        rsp_err   <= (w_sel_pslverr && w_sel_pready) || w_tmo || w_dec_err;
                        rsp_tmo   <= w_tmo;
                        r_state   <= ST_IDLE;
                        psel      <= '0;
                        penable   <= 1'b0;
                    end else if (r_cnt != '1) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
            // Acceptance in the done cycle overrides the return to IDLE.
            if (w_accept) begin
                r_state <= ST_SETUP;
                r_sel   <= cmd_sel;
                psel    <= w_psel_dec;
                penable <= 1'b0;
                pwrite  <= cmd_write;
                paddr   <= cmd_addr;
                pwdata  <= cmd_wdata;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_apb_master_nslv.sv
//==============================================================================
// Module : tb_apb_master_nslv
// Brief  : Scoreboard bench for apb_master_nslv (N_SLV=4, TIMEOUT=8, SELW=3).
// Rev    : 1.0
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_apb_master_nslv;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NS = 4;
    localparam int SW = 3;

    typedef struct {
        logic [DW-1:0] rdata;
        logic          err;
        logic          tmo;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            en;
    logic            cmd_valid;
    logic            cmd_ready;
    logic            cmd_write;
    logic [SW-1:0]   cmd_sel;
    logic [AW-1:0]   cmd_addr;
    logic [DW-1:0]   cmd_wdata;
    logic            rsp_full;
    logic            rsp_wen;
    logic [DW-1:0]   rsp_rdata;
    logic            rsp_err;
    logic            rsp_tmo;
    logic [1:0]      apb_state;
    logic [NS-1:0]   psel;
    logic            penable;
    logic            pwrite;
    logic [AW-1:0]   paddr;
    logic [DW-1:0]   pwdata;
    logic [NS*DW-1:0] prdata;
    logic [NS-1:0]   pready;
    logic [NS-1:0]   pslverr;

    int              n_checks = 0;
    int              n_fail   = 0;
    exp_t            sb_q[$];

    int              ws        = 0;
    bit              never_rdy = 1'b0;
    logic [DW-1:0]   slv_rdata[NS];
    logic [NS-1:0]   slv_err   = '0;
    int              wait_cnt  = 0;

    int              psel_cyc = 0;
    int              pen_cyc  = 0;
    int              pwd_bad  = 0;
    logic [DW-1:0]   exp_pwdata = '0;

    always #5 clk = ~clk;

    apb_master_nslv #(
        .AW      (AW),
        .DW      (DW),
        .N_SLV   (NS),
        .SELW    (SW),
        .TIMEOUT (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_sel   (cmd_sel),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_full  (rsp_full),
        .rsp_wen   (rsp_wen),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .rsp_tmo   (rsp_tmo),
        .apb_state (apb_state),
        .psel      (psel),
        .penable   (penable),
        .pwrite    (pwrite),
        .paddr     (paddr),
        .pwdata    (pwdata),
        .prdata    (prdata),
        .pready    (pready),
        .pslverr   (pslverr)
    );

    // Slave model: ready after ws wait states in ACCESS.
    always @(posedge clk) wait_cnt <= (penable && (psel != '0)) ? wait_cnt + 1 : 0;

    always_comb begin
        pready  = '0;
        pslverr = '0;
        prdata  = '0;
        for (int i = 0; i < NS; i++) begin
            pready[i]           = psel[i] && penable && !never_rdy && (wait_cnt == ws);
            pslverr[i]          = slv_err[i];
            prdata[i*DW +: DW]  = slv_rdata[i];
        end
    end

    always @(negedge clk) begin
        if (psel != '0) psel_cyc++;
        if (penable && psel != '0) pen_cyc++;
        if (psel != '0 && pwrite && pwdata !== exp_pwdata) pwd_bad++;
    end

    // Response monitor.
    always @(negedge clk) begin
        if (rst_n && rsp_wen) begin
            n_checks++;
            if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL rsp_unexpected: got rdata=0x%0h err=%0b tmo=%0b, expected no response",
                         rsp_rdata, rsp_err, rsp_tmo);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                if ({rsp_rdata, rsp_err, rsp_tmo} !== {e.rdata, e.err, e.tmo}) begin
                    n_fail++;
                    $display("FAIL rsp_compare: got rdata=0x%0h err=%0b tmo=%0b, expected rdata=0x%0h err=%0b tmo=%0b",
                             rsp_rdata, rsp_err, rsp_tmo, e.rdata, e.err, e.tmo);
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_obs();
        psel_cyc = 0;
        pen_cyc  = 0;
        pwd_bad  = 0;
    endtask

    task automatic send(input logic wr, input logic [SW-1:0] sel, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wdata, input logic [DW-1:0] e_rdata,
                        input logic e_err, input logic e_tmo);
        int   n = 0;
        exp_t e;
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_sel   = sel;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        #1;
        while (!cmd_ready && n < 50) begin
            step();
            n++;
        end
        if (!cmd_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout: got cmd_ready=0 expected 1 (sel=%0d)", sel);
        end else begin
            e.rdata = e_rdata;
            e.err   = e_err;
            e.tmo   = e_tmo;
            sb_q.push_back(e);
        end
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (sb_q.size() != 0 && n < 60) begin
            step();
            n++;
        end
        check(name, 64'(sb_q.size()), 64'd0);
    endtask

    initial begin
        int ready_seen;
        rst_n     = 1'b0;
        en        = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_sel   = '0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        rsp_full  = 1'b0;
        for (int i = 0; i < NS; i++) slv_rdata[i] = '0;

        step();
        step();
        check("reset_psel",      64'(psel),      64'd0);
        check("reset_penable",   64'(penable),   64'd0);
        check("reset_rsp_wen",   64'(rsp_wen),   64'd0);
        check("reset_paddr",     64'(paddr),     64'd0);
        check("reset_apb_state", 64'(apb_state), 64'd0);
        check("reset_cmd_ready", 64'(cmd_ready), 64'd0);
        rst_n = 1'b1;
        en    = 1'b1;
        step();
        check("idle_apb_state", 64'(apb_state), 64'd1);
        check("idle_cmd_ready", 64'(cmd_ready), 64'd1);

        // Read slave 2, ready in first ACCESS cycle.
        ws = 0;
        slv_rdata[2] = 32'hDEAD_BEEF;
        clear_obs();
        send(1'b0, 3'd2, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b0);
        drain("rd2_drain");
        check("rd2_psel_cycles",    64'(psel_cyc), 64'd2);
        check("rd2_penable_cycles", 64'(pen_cyc),  64'd1);

        // Write slave 0 with three wait states.
        ws = 3;
        exp_pwdata = 32'h55;
        clear_obs();
        send(1'b1, 3'd0, 32'h0000_0010, 32'h55, 32'h0, 1'b0, 1'b0);
        check("wr0_paddr", 64'(paddr), 64'h10);
        drain("wr0_drain");
        check("wr0_penable_cycles", 64'(pen_cyc),  64'd4);
        check("wr0_psel_cycles",    64'(psel_cyc), 64'd5);
        check("wr0_pwdata_stable",  64'(pwd_bad),  64'd0);

        // Back-to-back reads, slave 1 then slave 3.
        ws = 0;
        slv_rdata[1] = 32'h1111_0001;
        slv_rdata[3] = 32'h3333_0003;
        send(1'b0, 3'd1, 32'h0000_0200, 32'h0, 32'h1111_0001, 1'b0, 1'b0);
        send(1'b0, 3'd3, 32'h0000_0300, 32'h0, 32'h3333_0003, 1'b0, 1'b0);
        check("b2b_setup_psel",    64'(psel),    64'h8);
        check("b2b_setup_penable", 64'(penable), 64'd0);
        check("b2b_first_rsp_wen", 64'(rsp_wen), 64'd1);
        drain("b2b_drain");

        // Timeout on a slave that never responds.
        never_rdy = 1'b1;
        clear_obs();
        send(1'b0, 3'd3, 32'h0000_0400, 32'h0, 32'h0, 1'b1, 1'b1);
        drain("tmo_drain");
        check("tmo_penable_cycles", 64'(pen_cyc), 64'd8);
        check("tmo_psel_idle",      64'(psel),    64'd0);
        never_rdy = 1'b0;

        // Decode error: index beyond the slave count.
        clear_obs();
        send(1'b0, 3'd5, 32'h0000_0500, 32'h0, 32'h0, 1'b1, 1'b0);
        drain("dec_drain");
        check("dec_psel_cycles", 64'(psel_cyc), 64'd0);

        // PSLVERR on a read from slave 1.
        slv_rdata[1] = 32'h0;
        slv_err      = 4'b0010;
        send(1'b0, 3'd1, 32'h0000_0600, 32'h0, 32'h0, 1'b1, 1'b0);
        drain("slverr_drain");
        slv_err = '0;

        // Enable dropped while a write is waiting in ACCESS.
        ws = 3;
        exp_pwdata = 32'hAB;
        send(1'b1, 3'd2, 32'h0000_0020, 32'hAB, 32'h0, 1'b0, 1'b0);
        step();
        en        = 1'b0;
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_sel   = 3'd1;
        #1;
        check("dis_apb_state", 64'(apb_state), 64'd0);
        ready_seen = 0;
        for (int i = 0; i < 60 && sb_q.size() != 0; i++) begin
            if (cmd_ready) ready_seen++;
            step();
        end
        check("dis_drain",        64'(sb_q.size()), 64'd0);
        check("dis_no_ready",     64'(ready_seen),  64'd0);
        step();
        check("dis_psel_idle",    64'(psel),        64'd0);
        check("dis_cmd_ready",    64'(cmd_ready),   64'd0);
        check("dis_apb_state_end", 64'(apb_state),  64'd0);
        cmd_valid = 1'b0;
        en        = 1'b1;
        step();
        step();
        check("final_queue_empty", 64'(sb_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
